// File: rtl/bus.sv
// Single-master, two-slave system bus: registered grant, address decode to
// memory (slave 0) and factorial core (slave 1), one-cycle read-data return.
module bus #(
   parameter int unsigned           ADDR_W  = 16,
   parameter int unsigned           DATA_W  = 64,
   parameter logic [ADDR_W-1:0]     S0_BASE = 16'h0000,
   parameter logic [ADDR_W-1:0]     S0_LAST = 16'h07FF,
   parameter logic [ADDR_W-1:0]     S1_BASE = 16'h7000,
   parameter logic [ADDR_W-1:0]     S1_LAST = 16'h71FF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              m_req,
   input  logic              m_wr,
   input  logic [ADDR_W-1:0] m_addr,
   input  logic [DATA_W-1:0] m_dout,
   input  logic [DATA_W-1:0] s0_dout,
   input  logic [DATA_W-1:0] s1_dout,
   output logic              m_grant,
   output logic [DATA_W-1:0] m_din,
   output logic              s0_sel,
   output logic              s1_sel,
   output logic [ADDR_W-1:0] s_addr,
   output logic              s_wr,
   output logic [DATA_W-1:0] s_din
);

   // Encoding matches {s1_sel, s0_sel} so the capture is a direct cast.
   typedef enum logic [1:0] {
      RSEL_NONE = 2'b00,
      RSEL_S0   = 2'b01,
      RSEL_S1   = 2'b10
   } rsel_t;

   rsel_t rsel_q;

   logic in_s0;
   logic in_s1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_grant <= 1'b0;
      end else begin
         m_grant <= m_req;
      end
   end

   // Offset-from-base compare gives an inclusive range check without a
   // constant-true "addr >= 0" term when a base sits at address zero.
   always_comb begin
      in_s0 = (m_addr - S0_BASE) <= (S0_LAST - S0_BASE);
      in_s1 = (m_addr - S1_BASE) <= (S1_LAST - S1_BASE);
   end

   always_comb begin
      s0_sel = m_grant & in_s0;
      s1_sel = m_grant & in_s1;
   end

   always_comb begin
      s_addr = '0;
      s_din  = '0;
      s_wr   = 1'b0;
      if (m_grant) begin
         s_addr = m_addr;
         s_din  = m_dout;
         s_wr   = m_wr;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsel_q <= RSEL_NONE;
      end else begin
         rsel_q <= rsel_t'({s1_sel, s0_sel});
      end
   end

   always_comb begin
      m_din = '0;
      case (rsel_q)
         RSEL_S0: m_din = s0_dout;
         RSEL_S1: m_din = s1_dout;
         default: m_din = '0;
      endcase
   end

endmodule

// File: tb/tb_bus.sv
// Directed self-checking bench for the bus: reset, decode boundaries,
// read return latency, write forwarding, grant timing and async reset.
module tb_bus;

   localparam logic [63:0] D0 = 64'h1111111111111111;
   localparam logic [63:0] D1 = 64'h7777777777777777;

   logic        clk;
   logic        reset_n;
   logic        m_req;
   logic        m_wr;
   logic [15:0] m_addr;
   logic [63:0] m_dout;
   logic [63:0] s0_dout;
   logic [63:0] s1_dout;
   logic        m_grant;
   logic [63:0] m_din;
   logic        s0_sel;
   logic        s1_sel;
   logic [15:0] s_addr;
   logic        s_wr;
   logic [63:0] s_din;

   int unsigned n_checks;
   int unsigned n_fail;

   bus #(
      .ADDR_W (16),
      .DATA_W (64)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .m_req   (m_req),
      .m_wr    (m_wr),
      .m_addr  (m_addr),
      .m_dout  (m_dout),
      .s0_dout (s0_dout),
      .s1_dout (s1_dout),
      .m_grant (m_grant),
      .m_din   (m_din),
      .s0_sel  (s0_sel),
      .s1_sel  (s1_sel),
      .s_addr  (s_addr),
      .s_wr    (s_wr),
      .s_din   (s_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed,
                        input logic [63:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Address table with hand-decoded selects and the read data due next cycle.
   logic [15:0] v_addr [12] = '{16'h0000, 16'h0666, 16'h07FF, 16'h3000,
                                16'h0800, 16'h6FFF, 16'h7FFF, 16'h7200,
                                16'h7000, 16'h70DD, 16'h71FF, 16'h0666};
   logic        v_s0   [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic        v_s1   [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
   logic [63:0] v_din  [12] = '{D0, D0, D0, 64'h0, 64'h0, 64'h0,
                                64'h0, 64'h0, D1, D1, D1, D0};

   initial begin
      logic [63:0] prev_din;
      logic        req_prev;
      n_checks = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      m_req    = 1'b1;
      m_wr     = 1'b0;
      m_addr   = 16'h0000;
      m_dout   = '0;
      s0_dout  = D0;
      s1_dout  = D1;

      // Reset held across an edge with m_req high.
      #12;
      check("rst_grant", {63'd0, m_grant}, 64'd0);
      check("rst_s0sel", {63'd0, s0_sel}, 64'd0);
      check("rst_s1sel", {63'd0, s1_sel}, 64'd0);
      check("rst_swr",   {63'd0, s_wr}, 64'd0);
      check("rst_mdin",  m_din, 64'd0);
      check("rst_saddr", {48'd0, s_addr}, 64'd0);
      check("rst_sdin",  s_din, 64'd0);

      reset_n = 1'b1;
      #1;
      check("rel_grant_pre", {63'd0, m_grant}, 64'd0);
      step();
      check("rel_grant", {63'd0, m_grant}, 64'd1);

      // Reads across slave 0, unmapped holes, boundaries and slave 1.
      prev_din = '0;
      for (int unsigned i = 0; i < 12; i++) begin
         m_addr = v_addr[i];
         #1;
         check($sformatf("dec_s0_%h", v_addr[i]), {63'd0, s0_sel}, {63'd0, v_s0[i]});
         check($sformatf("dec_s1_%h", v_addr[i]), {63'd0, s1_sel}, {63'd0, v_s1[i]});
         check($sformatf("saddr_%h", v_addr[i]), {48'd0, s_addr}, {48'd0, v_addr[i]});
         check($sformatf("swr_%h", v_addr[i]), {63'd0, s_wr}, 64'd0);
         check($sformatf("mdin_pre_%h", v_addr[i]), m_din, prev_din);
         step();
         check($sformatf("mdin_%h", v_addr[i]), m_din, v_din[i]);
         prev_din = v_din[i];
      end

      // Read data follows a live slave output while the source is stable.
      s0_dout = 64'h0123456789ABCDEF;
      #1;
      check("mdin_live", m_din, 64'h0123456789ABCDEF);
      s0_dout = D0;

      // Write forwarding in the select cycle.
      m_wr   = 1'b1;
      m_dout = 64'hFFFFFFFFFFFFFFFF;
      m_addr = 16'h0010;
      #1;
      check("wr_swr",   {63'd0, s_wr}, 64'd1);
      check("wr_sdin",  s_din, 64'hFFFFFFFFFFFFFFFF);
      check("wr_s0sel", {63'd0, s0_sel}, 64'd1);
      m_req = 1'b0;
      #1;
      check("wr_swr_hold", {63'd0, s_wr}, 64'd1);
      step();
      check("drop_grant", {63'd0, m_grant}, 64'd0);
      check("drop_swr",   {63'd0, s_wr}, 64'd0);
      check("drop_s0sel", {63'd0, s0_sel}, 64'd0);
      check("drop_s1sel", {63'd0, s1_sel}, 64'd0);
      check("drop_sdin",  s_din, 64'd0);
      check("drop_saddr", {48'd0, s_addr}, 64'd0);
      check("drop_mdin",  m_din, D0);
      step();
      check("idle_mdin",  m_din, 64'd0);

      // Request toggling every cycle: grant trails by one edge.
      m_wr     = 1'b0;
      m_addr   = 16'h7000;
      req_prev = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         m_req = (i % 2 == 0) ? 1'b1 : 1'b0;
         #1;
         check($sformatf("tog_pre_%0d", i), {63'd0, m_grant}, {63'd0, req_prev});
         step();
         check($sformatf("tog_%0d", i), {63'd0, m_grant}, {63'd0, m_req});
         req_prev = m_req;
      end

      // Asynchronous reset in the middle of a granted slave 1 read.
      m_req = 1'b1;
      step();
      step();
      check("mid_grant", {63'd0, m_grant}, 64'd1);
      check("mid_mdin",  m_din, D1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_grant", {63'd0, m_grant}, 64'd0);
      check("async_s1sel", {63'd0, s1_sel}, 64'd0);
      check("async_mdin",  m_din, 64'd0);
      check("async_saddr", {48'd0, s_addr}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("post_rst_pre", {63'd0, m_grant}, 64'd0);
      step();
      check("post_rst_grant", {63'd0, m_grant}, 64'd1);
      check("post_rst_mdin",  m_din, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
